// File: rtl/wb_req_master_pkg.sv
// Shared definitions for the button-triggered Wishbone request master.
package wb_req_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_ACK,
    GAP,
    RD_REQ,
    RD_ACK
  } state_e;

  // Address of the responder's status/control register.
  localparam logic STATUS_ADDR = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; emits a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/wb_req_master.sv
// On a debounced button press, writes the status register then polls it until it reads zero.
module wb_req_master
  import wb_req_master_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned POLL_GAP        = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_btn,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic        o_addr,
  output logic [31:0] o_data,
  input  logic        i_stall,
  input  logic        i_ack,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic [3:0]  o_status,
  output logic        o_timeout
);

  localparam int unsigned CNT_MAX = (TIMEOUT > POLL_GAP) ? TIMEOUT : POLL_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       status_q, status_d;
  logic             press;
  logic             unused_data;

  assign unused_data = ^i_data[31:4];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_btn    (i_btn),
    .o_press  (press)
  );

  // One counter serves both the gap length and the timeout; it clears on every state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    status_d  = status_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (press) begin
          state_d   = WR_REQ;
          timeout_d = 1'b0;
        end
      end
      WR_REQ, RD_REQ: begin
        if (!i_stall)               state_d = (state_q == WR_REQ) ? WR_ACK : RD_ACK;
        else if (cnt_q == TMO_LAST) begin state_d = IDLE; timeout_d = 1'b1; end
      end
      WR_ACK: begin
        if (i_ack)                  state_d = GAP;
        else if (cnt_q == TMO_LAST) begin state_d = IDLE; timeout_d = 1'b1; end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = RD_REQ;
      end
      RD_ACK: begin
        if (i_ack) begin
          status_d = i_data[3:0];
          state_d  = (i_data[3:0] == 4'd0) ? IDLE : GAP;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;

    cyc_d  = state_d inside {WR_REQ, WR_ACK, RD_REQ, RD_ACK};
    stb_d  = state_d inside {WR_REQ, RD_REQ};
    we_d   = (state_d == WR_REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      status_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      status_q  <= status_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_cyc     = cyc_q;
  assign o_stb     = stb_q;
  assign o_we      = we_q;
  assign o_addr    = STATUS_ADDR;
  assign o_data    = '0;
  assign o_busy    = busy_q;
  assign o_status  = status_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_wb_req_master.sv
// Directed bench for wb_req_master: debounce, stall, polling, timeout, dropped press, mid-transfer reset.
module tb_wb_req_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn = 1'b0;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        cyc, stb, we, addr, busy, tmo;
  logic [31:0] wdata;
  logic [3:0]  status;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_req_master #(
    .DEBOUNCE_CYCLES(16),
    .POLL_GAP       (4),
    .TIMEOUT        (255)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_btn    (btn),
    .o_cyc    (cyc),
    .o_stb    (stb),
    .o_we     (we),
    .o_addr   (addr),
    .o_data   (wdata),
    .i_stall  (stall),
    .i_ack    (ack),
    .i_data   (rdata),
    .o_busy   (busy),
    .o_status (status),
    .o_timeout(tmo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_btn;
    btn = 1'b0;
    repeat (25) tick;
  endtask

  // Completes any outstanding transfer with immediate acks and a zero status.
  task automatic drain;
    stall = 1'b0;
    ack   = 1'b1;
    rdata = '0;
    for (int i = 0; i < 400 && busy; i++) tick;
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    checks++;
    if ({cyc, stb, we, busy, tmo} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {cyc, stb, we, busy, tmo});
    end
    checks++;
    if (status !== 4'd0) begin errors++; $display("FAIL reset_status: got %0d want 0", status); end
    checks++;
    if ({addr, wdata} !== 33'd0) begin errors++; $display("FAIL reset_addr_data: got %h want 0", {addr, wdata}); end
    rst_n = 1'b1;
    tick;
    checks++;
    if ({cyc, busy} !== 2'b00) begin errors++; $display("FAIL reset_release_idle: got %b want 00", {cyc, busy}); end
  endtask

  task automatic test_debounce;
    int hi[3] = '{5, 12, 15};
    int lo[3] = '{3, 2, 4};
    int glitch_stb = 0;
    int first = 0;
    int writes = 0;
    int reads = 0;
    stall = 1'b0; ack = 1'b1; rdata = '0;
    for (int g = 0; g < 3; g++) begin
      btn = 1'b1;
      for (int i = 0; i < hi[g]; i++) begin tick; if (stb) glitch_stb++; end
      btn = 1'b0;
      for (int i = 0; i < lo[g]; i++) begin tick; if (stb) glitch_stb++; end
    end
    checks++;
    if (glitch_stb !== 0) begin errors++; $display("FAIL glitch_ignored: got %0d strobes want 0", glitch_stb); end
    btn = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick;
      if (stb && first == 0) first = i;
      if (stb && we) writes++;
      if (stb && !we) reads++;
    end
    checks++;
    if (first < 18 || first > 20) begin errors++; $display("FAIL debounce_latency: got %0d want 18..20", first); end
    checks++;
    if (writes !== 1) begin errors++; $display("FAIL debounce_single_write: got %0d want 1", writes); end
    checks++;
    if (reads !== 1) begin errors++; $display("FAIL debounce_single_read: got %0d want 1", reads); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL debounce_idle: got busy=%b want 0", busy); end
    ack = 1'b0;
    release_btn;
  endtask

  task automatic test_stall;
    int n = 0;
    stall = 1'b1; ack = 1'b0;
    btn = 1'b1;
    while (!stb && n < 40) begin tick; n++; end
    checks++;
    if (stb !== 1'b1) begin errors++; $display("FAIL stall_start: got stb=%b want 1", stb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cyc, stb, we} !== 3'b111) begin
        errors++; $display("FAIL stall_hold[%0d]: got cyc,stb,we=%b want 111", i, {cyc, stb, we});
      end
      if (i == 3) stall = 1'b0;
      tick;
    end
    checks++;
    if ({cyc, stb} !== 2'b10) begin errors++; $display("FAIL stall_wr_ack: got cyc,stb=%b want 10", {cyc, stb}); end
    ack = 1'b1;
    tick;
    ack = 1'b0;
    checks++;
    if ({cyc, busy} !== 2'b01) begin errors++; $display("FAIL stall_ack_cyc_drop: got cyc,busy=%b want 01", {cyc, busy}); end
    drain;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_drain: got busy=%b want 0", busy); end
    release_btn;
  endtask

  task automatic test_polling;
    logic [3:0] data_tab[3] = '{4'd5, 4'd3, 4'd0};
    int n = 0;
    int rd_reqs = 0;
    int idx = 0;
    int gap = 0;
    int gaps_seen = 0;
    int last_ack_c = -10;
    int fall_c = -1;
    logic last_we = 1'b1;
    logic ack_rd;
    stall = 1'b0; ack = 1'b0;
    btn = 1'b1;
    while (!stb && n < 40) begin tick; n++; end
    checks++;
    if (stb !== 1'b1) begin errors++; $display("FAIL poll_start: got stb=%b want 1", stb); end
    for (int c = 0; c < 200; c++) begin
      if (!busy) begin fall_c = c; break; end
      if (stb) begin last_we = we; if (!we) rd_reqs++; end
      if (!cyc) gap++;
      else if (gap != 0) begin
        gaps_seen++;
        checks++;
        if (gap !== 4) begin errors++; $display("FAIL poll_gap_len: got %0d want 4", gap); end
        gap = 0;
      end
      ack    = cyc && !stb;
      ack_rd = ack && !last_we;
      rdata  = (ack_rd && idx < 3) ? {28'd0, data_tab[idx]} : 32'd0;
      tick;
      if (ack_rd && idx < 3) begin
        checks++;
        if (status !== data_tab[idx]) begin
          errors++; $display("FAIL poll_status[%0d]: got %0d want %0d", idx, status, data_tab[idx]);
        end
        idx++;
        last_ack_c = c;
      end
    end
    ack = 1'b0;
    checks++;
    if (rd_reqs !== 3) begin errors++; $display("FAIL poll_read_count: got %0d want 3", rd_reqs); end
    checks++;
    if (gaps_seen !== 3) begin errors++; $display("FAIL poll_gap_count: got %0d want 3", gaps_seen); end
    checks++;
    if (status !== 4'd0) begin errors++; $display("FAIL poll_final_status: got %0d want 0", status); end
    checks++;
    if (fall_c !== last_ack_c + 1) begin
      errors++; $display("FAIL poll_busy_fall: got cycle %0d want %0d", fall_c, last_ack_c + 1);
    end
    release_btn;
  endtask

  task automatic test_timeout;
    int n = 0;
    stall = 1'b0; ack = 1'b0;
    btn = 1'b1;
    while (!stb && n < 40) begin tick; n++; end
    tick;
    checks++;
    if ({cyc, stb} !== 2'b10) begin errors++; $display("FAIL tmo_wr_ack: got cyc,stb=%b want 10", {cyc, stb}); end
    n = 0;
    while (cyc && n < 300) begin n++; tick; end
    checks++;
    if (n !== 255) begin errors++; $display("FAIL tmo_cycles: got %0d want 255", n); end
    checks++;
    if ({tmo, stb, busy} !== 3'b100) begin
      errors++; $display("FAIL tmo_abort: got tmo,stb,busy=%b want 100", {tmo, stb, busy});
    end
    release_btn;
    checks++;
    if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", tmo); end
    btn = 1'b1;
    n = 0;
    while (!stb && n < 40) begin tick; n++; end
    checks++;
    if ({stb, tmo} !== 2'b10) begin errors++; $display("FAIL tmo_cleared: got stb,tmo=%b want 10", {stb, tmo}); end
    drain;
    release_btn;
  endtask

  task automatic test_second_press;
    int n = 0;
    int writes = 0;
    int rd_idx = 0;
    int late_stb = 0;
    logic done = 1'b0;
    logic last_we = 1'b1;
    stall = 1'b0; ack = 1'b0;
    btn = 1'b1;
    while (!stb && n < 40) begin tick; n++; end
    for (int c = 0; c < 400; c++) begin
      if (!busy) begin done = 1'b1; break; end
      if (stb && we) writes++;
      if (stb) last_we = we;
      if (c == 5) btn = 1'b0;
      if (c == 30) btn = 1'b1;
      ack   = cyc && !stb;
      rdata = (rd_idx < 12) ? 32'd1 : 32'd0;
      if (ack && !last_we) rd_idx++;
      tick;
    end
    ack = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL press2_done: got %b want 1", done); end
    checks++;
    if (writes !== 1) begin errors++; $display("FAIL press2_writes: got %0d want 1", writes); end
    checks++;
    if (rd_idx !== 13) begin errors++; $display("FAIL press2_reads: got %0d want 13", rd_idx); end
    for (int i = 0; i < 40; i++) begin tick; if (stb) late_stb++; end
    checks++;
    if (late_stb !== 0) begin errors++; $display("FAIL press2_not_queued: got %0d strobes want 0", late_stb); end
    release_btn;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    stall = 1'b0; ack = 1'b0;
    btn = 1'b1;
    while (!(stb && !we) && n < 80) begin
      ack = cyc && !stb;
      tick;
      n++;
    end
    stall = 1'b1;
    ack = 1'b0;
    checks++;
    if ({cyc, stb, we} !== 3'b110) begin errors++; $display("FAIL rst_mid_rd_req: got cyc,stb,we=%b want 110", {cyc, stb, we}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, stb, busy} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_async_drop: got cyc,stb,busy=%b want 000", {cyc, stb, busy});
    end
    btn = 1'b0;
    stall = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if ({cyc, busy} !== 2'b00) begin errors++; $display("FAIL rst_mid_idle: got cyc,busy=%b want 00", {cyc, busy}); end
    repeat (25) tick;
    checks++;
    if ({cyc, busy} !== 2'b00) begin errors++; $display("FAIL rst_mid_stays_idle: got cyc,busy=%b want 00", {cyc, busy}); end
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_stall;
    test_polling;
    test_timeout;
    test_second_press;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
